accum_warp_looper_memofs_stage: RTL and testbench

- Downstream neighbour of the accumulation warp-looper index stage: consumes its per-warp packets (config id, warp id, block/accum offsets, retire, islast) and produces a linear global memory offset per packet.
- Computes addr = mstart[id] + sum over d of (bofs[d]+aofs[d])*mlinear[id][d].
- Two-stage rdy/ack pipeline, full throughput, backpressure-safe; feeds the memory request/address-coalescing stage.

---
 rtl/accum_warp_looper_memofs_stage.sv | 120 ++++++++++++
 tb/tb_accum_warp_looper_memofs_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/accum_warp_looper_memofs_stage.sv
// Per-warp linear memory offset: addr = mstart[id] + sum_d (bofs+aofs)*mlinear.
// Two-stage rdy/ack pipeline: stage 1 forms per-dim products, stage 2 sums.
module accum_warp_looper_memofs_stage #(
  parameter int N_CFG    = 4,
  parameter int WBW      = 16,
  parameter int VDIM     = 4,
  parameter int MAX_WARP = 4,
  parameter int GBW      = 32,
  parameter int WID_BW   = (MAX_WARP > 1) ? $clog2(MAX_WARP) : 1,
  parameter int NCFG_BW  = $clog2(N_CFG + 1)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 src_rdy,
  output logic                                 src_ack,
  input  logic [NCFG_BW-1:0]                   i_id,
  input  logic [WID_BW-1:0]                    i_warpid,
  input  logic [VDIM-1:0][WBW-1:0]             i_bofs,
  input  logic [VDIM-1:0][WBW-1:0]             i_aofs,
  input  logic                                 i_retire,
  input  logic                                 i_islast,
  input  logic [N_CFG-1:0][GBW-1:0]            i_mstart,
  input  logic [N_CFG-1:0][VDIM-1:0][GBW-1:0]  i_mlinear,
  output logic                                 dst_rdy,
  input  logic                                 dst_ack,
  output logic [NCFG_BW-1:0]                   o_id,
  output logic [WID_BW-1:0]                    o_warpid,
  output logic                                 o_retire,
  output logic                                 o_islast,
  output logic [GBW-1:0]                       o_addr
);

  typedef struct packed {
    logic [NCFG_BW-1:0] id;
    logic [WID_BW-1:0]  wid;
    logic               retire;
    logic               islast;
  } side_t;

  logic                       s1_v, s2_v, s1_adv;
  side_t                      s1_side, s2_side, in_side;
  logic [GBW-1:0]             s1_base, base, addr_nx;
  logic [VDIM-1:0][GBW-1:0]   s1_prod, prod, stride;
  logic [VDIM-1:0][WBW-1:0]   sum;

  assign s1_adv  = s1_v && (!s2_v || dst_ack);
  assign src_ack = src_rdy && (!s1_v || s1_adv);
  assign dst_rdy = s2_v;

  assign in_side = '{id: i_id, wid: i_warpid,
                     retire: i_retire, islast: i_islast};

  // Out-of-range ids match no entry, so base and strides stay zero.
  always_comb begin
    base   = '0;
    stride = '0;
    for (int c = 0; c < N_CFG; c++) begin
      if (i_id == NCFG_BW'(c)) begin
        base   = i_mstart[c];
        stride = i_mlinear[c];
      end
    end
  end

  always_comb begin
    sum  = '0;
    prod = '0;
    for (int d = 0; d < VDIM; d++) begin
      sum[d]  = i_bofs[d] + i_aofs[d];
      prod[d] = {{(GBW-WBW){1'b0}}, sum[d]} * stride[d];
    end
  end

  always_comb begin
    addr_nx = s1_base;
    for (int d = 0; d < VDIM; d++) begin
      addr_nx = addr_nx + s1_prod[d];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s1_v    <= 1'b0;
      s1_side <= '0;
      s1_base <= '0;
      s1_prod <= '0;
    end else begin
      if (src_ack) begin
        s1_v    <= 1'b1;
        s1_side <= in_side;
        s1_base <= base;
        s1_prod <= prod;
      end else if (s1_adv) begin
        s1_v    <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s2_v    <= 1'b0;
      s2_side <= '0;
      o_addr  <= '0;
    end else begin
      if (s1_adv) begin
        s2_v    <= 1'b1;
        s2_side <= s1_side;
        o_addr  <= addr_nx;
      end else if (dst_ack) begin
        s2_v    <= 1'b0;
      end
    end
  end

  assign o_id     = s2_side.id;
  assign o_warpid = s2_side.wid;
  assign o_retire = s2_side.retire;
  assign o_islast = s2_side.islast;

endmodule

// File: tb/tb_accum_warp_looper_memofs_stage.sv
// Directed bench for the memory-offset stage with a queue scoreboard.
// Packets are modelled on acceptance and compared in order on output.
module tb_accum_warp_looper_memofs_stage;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    src_rdy, src_ack, dst_rdy, dst_ack;
  logic [2:0]              id, o_id;
  logic [1:0]              wid, o_warpid;
  logic [3:0][15:0]        bofs, aofs;
  logic                    ret, last, o_retire, o_islast;
  logic [3:0][31:0]        mstart;
  logic [3:0][3:0][31:0]   mlin;
  logic [31:0]             o_addr;

  logic [38:0]             q[$];
  logic [38:0]             exp_pkt;
  int                      ncmp = 0;
  int                      nfail = 0;
  bit                      last_acc;
  int                      k;

  always #5 clk = ~clk;

  accum_warp_looper_memofs_stage dut (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .src_rdy   (src_rdy),
    .src_ack   (src_ack),
    .i_id      (id),
    .i_warpid  (wid),
    .i_bofs    (bofs),
    .i_aofs    (aofs),
    .i_retire  (ret),
    .i_islast  (last),
    .i_mstart  (mstart),
    .i_mlinear (mlin),
    .dst_rdy   (dst_rdy),
    .dst_ack   (dst_ack),
    .o_id      (o_id),
    .o_warpid  (o_warpid),
    .o_retire  (o_retire),
    .o_islast  (o_islast),
    .o_addr    (o_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [38:0] model();
    logic [31:0] a;
    logic [15:0] s;
    a = 32'h0;
    if (id < 3'd4) begin
      a = mstart[id[1:0]];
      for (int d = 0; d < 4; d++) begin
        s = bofs[d] + aofs[d];
        a = a + {16'h0, s} * mlin[id[1:0]][d];
      end
    end
    return {id, wid, ret, last, a};
  endfunction

  function automatic logic [38:0] obs_pkt();
    return {o_id, o_warpid, o_retire, o_islast, o_addr};
  endfunction

  task automatic tick();
    @(negedge clk);
    if (dst_rdy && dst_ack) begin
      if (q.size() == 0) chk("spurious_out", 64'(dst_rdy), 64'(0));
      else begin
        exp_pkt = q.pop_front();
        chk("out_pkt", 64'(obs_pkt()), 64'(exp_pkt));
      end
    end
    last_acc = src_rdy && src_ack;
    if (last_acc) q.push_back(model());
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    src_rdy = 1'b0;
    dst_ack = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic set_pkt(input int n);
    id   = 3'(n % 4);
    wid  = 2'(n % 4);
    ret  = (n % 3 == 0);
    last = 1'b0;
    for (int d = 0; d < 4; d++) begin
      bofs[d] = 16'($urandom_range(0, 16'hFFFF));
      aofs[d] = 16'($urandom_range(0, 16'hFFFF));
    end
  endtask

  initial begin
    rst_n = 1'b0; src_rdy = 1'b0; dst_ack = 1'b0;
    id = '0; wid = '0; bofs = '0; aofs = '0; ret = 1'b0; last = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mstart[c] = 32'h1000 * (c + 1);
      for (int d = 0; d < 4; d++) mlin[c][d] = 32'(c * 8 + d + 1);
    end
    mstart[1] = 32'h100;
    mlin[1]   = {32'd0, 32'd0, 32'd64, 32'd4};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dst_rdy", 64'(dst_rdy), 64'(0));
    chk("rst_addr", 64'(o_addr), 64'(0));
    chk("rst_src_ack", 64'(src_ack), 64'(0));
    rst_n = 1'b1;
    tick();

    // single packet with latency check
    dst_ack = 1'b1; src_rdy = 1'b1;
    id = 3'd1; wid = 2'd2; ret = 1'b1; last = 1'b0;
    bofs = {16'd0, 16'd0, 16'd0, 16'd2};
    aofs = {16'd0, 16'd0, 16'd3, 16'd1};
    tick();
    chk("single_acc", 64'(last_acc), 64'(1));
    chk("single_model", 64'(q[0]), 64'({3'd1, 2'd2, 1'b1, 1'b0, 32'h1CC}));
    src_rdy = 1'b0;
    chk("lat_t1", 64'(dst_rdy), 64'(0));
    tick();
    chk("lat_t2", 64'(dst_rdy), 64'(1));
    drain();

    // back-to-back stream
    dst_ack = 1'b1; src_rdy = 1'b1;
    for (int n = 0; n < 8; n++) begin
      set_pkt(n);
      tick();
      chk("stream_ack", 64'(last_acc), 64'(1));
    end
    drain();

    // backpressure: two packets buffered, then release
    dst_ack = 1'b0; src_rdy = 1'b1; k = 0;
    set_pkt(k);
    repeat (5) begin
      tick();
      if (last_acc) begin k++; set_pkt(k); end
    end
    #1;
    chk("bp_buffered", 64'(k), 64'(2));
    chk("bp_src_ack_low", 64'(src_ack), 64'(0));
    chk("bp_dst_rdy", 64'(dst_rdy), 64'(1));
    chk("bp_hold", 64'(obs_pkt()), 64'(q[0]));
    dst_ack = 1'b1;
    for (int i = 0; i < 20 && k < 6; i++) begin
      tick();
      if (last_acc) begin
        k++;
        if (k < 6) set_pkt(k); else src_rdy = 1'b0;
      end
    end
    chk("bp_sent", 64'(k), 64'(6));
    drain();

    // offset and address wrap on config 2
    mstart[2] = 32'hFFFF_FFFF;
    mlin[2]   = {32'd0, 32'd0, 32'd0, 32'd1};
    src_rdy = 1'b1; id = 3'd2; wid = 2'd1; ret = 1'b0; last = 1'b0;
    bofs = {16'd0, 16'd0, 16'd0, 16'hFFFF};
    aofs = {16'd0, 16'd0, 16'd0, 16'd2};
    tick();
    chk("wrap_model", 64'(q[q.size()-1]), 64'({3'd2, 2'd1, 2'b00, 32'h0}));
    // out-of-range id carries islast, addr forced to zero
    id = 3'd4; wid = 2'd3; last = 1'b1;
    bofs = {16'd7, 16'd5, 16'd3, 16'd1};
    aofs = {16'd1, 16'd2, 16'd3, 16'd4};
    tick();
    chk("oor_model", 64'(q[q.size()-1]), 64'({3'd4, 2'd3, 2'b01, 32'h0}));
    drain();

    // async reset with both stages full
    dst_ack = 1'b0; src_rdy = 1'b1; last = 1'b0;
    set_pkt(1); tick();
    set_pkt(2); tick();
    src_rdy = 1'b0;
    tick();
    chk("pre_rst_full", 64'(dst_rdy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dst_rdy", 64'(dst_rdy), 64'(0));
    chk("arst_addr", 64'(o_addr), 64'(0));
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; dst_ack = 1'b1; src_rdy = 1'b1;
    set_pkt(3);
    tick();
    src_rdy = 1'b0;
    chk("post_rst_t1", 64'(dst_rdy), 64'(0));
    tick();
    chk("post_rst_t2", 64'(dst_rdy), 64'(1));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
